multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Datapath for the MIPS multicycle core. It sits directly downstream of the multicycle control FSM, consuming its control vector every cycle and returning the current instruction opcode. It holds the PC, the instruction register (IR), the memory data register (MDR), the A/B operand latches, ALUOut, a 32x32 register file, the ALU and ALU decode. It drives a single unified instruction/data memory port.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  in  1  load IR from mem_rdata
- RegDst  in  1  write register select: 0 = rt (IR[20:16]), 1 = rd (IR[15:11])
- MemRead  in  1  passed through to mem_read
- MemToReg  in  1  register write data: 0 = ALUOut, 1 = MDR
- MemWrite  in  1  passed through to mem_write
- ALUSrcA  in  1  ALU operand A: 0 = PC, 1 = A
- ALUSrcB  in  2  ALU operand B: 00 = B, 01 = 32'd4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- RegWrite  in  1  register file write enable
- ALUOp  in  2  00 = add, 01 = sub, 10 = decode funct, 11 = add
- PCSource  in  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = current PC (hold)
- PCWrite  in  1  unconditional PC load
- PCWriteCond  in  1  PC load when ALU zero = 1
- opcode  out  6  IR[31:26], to the control FSM
- mem_addr  out  32  unified memory byte address
- mem_wdata  out  32  store data (= B)
- mem_rdata  in  32  memory read data; asynchronous read, valid in the same cycle as mem_addr
- mem_read  out  1  = MemRead
- mem_write  out  1  = MemWrite; memory writes on the rising edge
- pc  out  32  current PC (debug/trace)
- alu_zero  out  1  combinational ALU zero flag

## Operation
- Immediate: imm = IR[15:0], sign-extended to 32 bits. Jump target = {PC[31:28], IR[25:0], 2'b00}.
- ALU decode for ALUOp = 10, keyed on funct = IR[5:0]:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
  - 0x2A slt: signed compare, result 32'd1 or 32'd0.
  - Any other funct: result 32'd0.
- Arithmetic is 32-bit wrap-around; no overflow detection and no exception.
- alu_zero = (ALU result == 0).
- PC update at the clock edge when PCWrite | (PCWriteCond & alu_zero). The value loaded is selected by PCSource.
- IR loads mem_rdata only when IRWrite = 1; otherwise it holds.
- Loaded unconditionally every cycle:
  - MDR <= mem_rdata.
  - A <= RF[IR[25:21]] and B <= RF[IR[20:16]], using the current IR.
  - ALUOut <= ALU result.
- Register file:
  - Two asynchronous read ports.
  - One write port: address per RegDst, data per MemToReg.
  - The write is ignored when the address is 0. R0 always reads 0.
- Combinational outputs: mem_addr = IorD ? ALUOut : PC; mem_wdata = B; opcode = IR[31:26].

## Timing
- Reset values, applied immediately on reset assertion:
  - PC = RESET_PC.
  - IR, MDR, A, B, ALUOut = 0.
  - All 32 registers = 0.
  - As a result, opcode = 0, mem_addr = RESET_PC (with IorD = 0), mem_wdata = 0, pc = RESET_PC.
- Reset asserted mid-instruction aborts it. Every register returns to its reset value and no memory write is generated by the datapath.
- Read-during-write in the register file: a read of a register being written in the same cycle returns the old value. The new value is visible the cycle after the edge.
- A/B latency: A/B reflect a newly loaded IR one cycle after IR loads. When IRWrite and RegWrite are both asserted in one cycle, IR loads and the register write addresses the pre-load IR fields.
- Branch decision: a PCWriteCond branch uses alu_zero from the same cycle. Branch target = ALUOut, computed in the preceding cycle.
- With PCWrite and PCWriteCond both set, PCWrite dominates (the load is unconditional).
- Instruction cycle counts under the FSM:
  - lw: 5 cycles.
  - R-type, sw, addi: 4 cycles.
  - beq, j: 3 cycles.

## Test plan
- Reset then release; drive the FSM IF vector (IRWrite = 1, ALUSrcB = 01, PCWrite = 1), mem_rdata = 0x2008_0005. Required: IR = 0x2008_0005, opcode = 0x08, PC = 4.
- addi $t0, $0, 5, driven through ID / ADDI / ADDICOMP vectors -> RF[8] = 5. A further R-type add $t1, $t0, $t0 (0x0108_4820) -> RF[9] = 10.
- Store then load:
  - sw $t1, 8($0) -> store cycle shows mem_addr = 8, mem_wdata = 10, mem_write = 1.
  - lw $t2, 8($0), with memory returning 10 -> RF[10] = 10, and the write-back takes MDR.
- beq taken and not taken, starting from PC = 0x10, offset +3:
  - Equal operands -> PC = 0x20.
  - Unequal operands -> PC stays 0x14.
- j 0x0000040 with PC = 0x1000_0004 -> PC = 0x1000_0100. Also check that slt with -1 < 1 returns 1, and that a write to R0 leaves R0 = 0.
- Assert reset in the LW state, after IorD = 1 has been driven -> on assertion, PC = RESET_PC and IR = 0, and all registers read 0 after reset.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Datapath for the multicycle MIPS core. Holds the architectural state
// (PC, IR, MDR, A, B, ALUOut, 32x32 register file) plus the ALU and its
// decode. The control FSM drives the control vector every cycle and reads
// back the opcode. One unified instruction/data memory port with an
// asynchronous read and a write on the rising edge.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic        RegDst,
    input  logic        MemRead,
    input  logic        MemToReg,
    input  logic        MemWrite,
    input  logic        ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic        RegWrite,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  PCSource,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    output logic [5:0]  opcode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] pc,
    output logic        alu_zero
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NONE
    } alu_fn_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic [31:0] imm_ext;
    logic [31:0] jump_target;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    alu_fn_e     alu_fn;
    logic        pc_en;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign imm_ext     = {{16{ir_q[15]}}, ir_q[15:0]};
    assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

    // ALU operand selection
    always_comb begin
        src_a = ALUSrcA ? a_q : pc_q;
        src_b = b_q;
        case (ALUSrcB)
            2'b00:   src_b = b_q;
            2'b01:   src_b = 32'd4;
            2'b10:   src_b = imm_ext;
            2'b11:   src_b = {imm_ext[29:0], 2'b00};
            default: src_b = b_q;
        endcase
    end

    // ALU function decode (ALUOp, then funct for R-type) and the ALU itself
    always_comb begin
        alu_fn = ALU_ADD;
        case (ALUOp)
            2'b01: alu_fn = ALU_SUB;
            2'b10: begin
                case (ir_q[5:0])
                    6'h20:   alu_fn = ALU_ADD;
                    6'h22:   alu_fn = ALU_SUB;
                    6'h24:   alu_fn = ALU_AND;
                    6'h25:   alu_fn = ALU_OR;
                    6'h2A:   alu_fn = ALU_SLT;
                    default: alu_fn = ALU_NONE;
                endcase
            end
            default: alu_fn = ALU_ADD;
        endcase

        alu_result = 32'd0;
        case (alu_fn)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_SLT:  alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            default:  alu_result = 32'd0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

    // Next values for PC and the per-cycle latches; A/B read through the current IR
    always_comb begin
        pc_en = PCWrite | (PCWriteCond & alu_zero);
        pc_d  = pc_q;
        if (pc_en) begin
            case (PCSource)
                2'b00:   pc_d = alu_result;
                2'b01:   pc_d = alu_out_q;
                2'b10:   pc_d = jump_target;
                default: pc_d = pc_q;
            endcase
        end
        ir_d      = IRWrite ? mem_rdata : ir_q;
        mdr_d     = mem_rdata;
        a_d       = rf_q[ir_q[25:21]];
        b_d       = rf_q[ir_q[20:16]];
        alu_out_d = alu_result;
    end

    // Register file write; fields come from the IR as it stands this cycle,
    // so a simultaneous IR load does not redirect the write. R0 is never written.
    always_comb begin
        rf_waddr = RegDst ? ir_q[15:11] : ir_q[20:16];
        rf_wdata = MemToReg ? mdr_q : alu_out_q;
        rf_d     = rf_q;
        if (RegWrite && (rf_waddr != 5'd0)) begin
            rf_d[rf_waddr] = rf_wdata;
        end
    end

    // Architectural registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            mdr_q     <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_out_q <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
        end
    end

    // Register file storage; reads see the pre-edge contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    assign opcode    = ir_q[31:26];
    assign mem_addr  = IorD ? alu_out_q : pc_q;
    assign mem_wdata = b_q;
    assign mem_read  = MemRead;
    assign mem_write = MemWrite;
    assign pc        = pc_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: a table of per-cycle control
// vectors that walks a small program (addi, add, sw, lw, beq, j, slt),
// followed by register read-back through the B latch and a mid-lw reset.
module tb_multicycle_datapath;

  typedef struct packed {
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;

  typedef struct {
    ctrl_t       ctrl;
    logic [31:0] rdata;
    logic [4:0]  mask;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mwr;
    logic        zero;
  } vec_t;

  localparam logic [4:0] M_PC   = 5'b00001;
  localparam logic [4:0] M_OP   = 5'b00010;
  localparam logic [4:0] M_ADDR = 5'b00100;
  localparam logic [4:0] M_WR   = 5'b01000;
  localparam logic [4:0] M_ZERO = 5'b10000;

  localparam ctrl_t C_IDLE   = '{default: '0};
  localparam ctrl_t C_FETCH  = '{ir_write: 1'b1, mem_read: 1'b1, alu_src_b: 2'b01, pc_write: 1'b1, default: '0};
  localparam ctrl_t C_DECODE = '{alu_src_b: 2'b11, default: '0};
  localparam ctrl_t C_MEMADR = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam ctrl_t C_MEMRD  = '{iord: 1'b1, mem_read: 1'b1, default: '0};
  localparam ctrl_t C_MEMWB  = '{mem_to_reg: 1'b1, reg_write: 1'b1, default: '0};
  localparam ctrl_t C_MEMWR  = '{iord: 1'b1, mem_write: 1'b1, default: '0};
  localparam ctrl_t C_EXEC   = '{alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
  localparam ctrl_t C_ALUWB  = '{reg_dst: 1'b1, reg_write: 1'b1, default: '0};
  localparam ctrl_t C_BRANCH = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_source: 2'b01, pc_write_cond: 1'b1, default: '0};
  localparam ctrl_t C_ADDIEX = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam ctrl_t C_ADDIWB = '{reg_write: 1'b1, default: '0};
  localparam ctrl_t C_JUMP   = '{pc_source: 2'b10, pc_write: 1'b1, default: '0};
  localparam ctrl_t C_IRONLY = '{ir_write: 1'b1, default: '0};

  logic        clk;
  logic        reset;
  logic        IorD, IRWrite, RegDst, MemRead, MemToReg, MemWrite, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        RegWrite;
  logic [1:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        PCWrite, PCWriteCond;
  logic [5:0]  opcode;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        mem_read, mem_write, alu_zero;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[$];

  multicycle_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemRead    (MemRead),
    .MemToReg   (MemToReg),
    .MemWrite   (MemWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .opcode     (opcode),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .pc         (pc),
    .alu_zero   (alu_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input ctrl_t c, input logic [31:0] rdata);
    IorD        = c.iord;
    IRWrite     = c.ir_write;
    RegDst      = c.reg_dst;
    MemRead     = c.mem_read;
    MemToReg    = c.mem_to_reg;
    MemWrite    = c.mem_write;
    ALUSrcA     = c.alu_src_a;
    ALUSrcB     = c.alu_src_b;
    RegWrite    = c.reg_write;
    ALUOp       = c.alu_op;
    PCSource    = c.pc_source;
    PCWrite     = c.pc_write;
    PCWriteCond = c.pc_write_cond;
    mem_rdata   = rdata;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input ctrl_t c, input logic [31:0] rd, input logic [4:0] m,
                               input logic [31:0] p, input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] wd, input logic mwr, input logic z);
    vec_t v;
    v.ctrl = c; v.rdata = rd; v.mask = m; v.pc = p; v.op = op;
    v.addr = addr; v.wdata = wd; v.mwr = mwr; v.zero = z;
    return v;
  endfunction

  function automatic vec_t mk0(input ctrl_t c);
    return mkv(c, 32'h0, 5'b0, 32'h0, 6'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  // One clock cycle: drive at posedge+1, combinational checks at the negedge,
  // registered checks at the following posedge+1.
  task automatic step(input vec_t v, input string tag);
    drive(v.ctrl, v.rdata);
    @(negedge clk);
    if (v.mask[2]) begin
      check({tag, ".mem_addr"}, mem_addr, v.addr);
      check({tag, ".mem_read"}, {31'b0, mem_read}, {31'b0, v.ctrl.mem_read});
    end
    if (v.mask[3]) begin
      check({tag, ".mem_wdata"}, mem_wdata, v.wdata);
      check({tag, ".mem_write"}, {31'b0, mem_write}, {31'b0, v.mwr});
    end
    if (v.mask[4]) check({tag, ".alu_zero"}, {31'b0, alu_zero}, {31'b0, v.zero});
    @(posedge clk); #1;
    if (v.mask[0]) check({tag, ".pc"}, pc, v.pc);
    if (v.mask[1]) check({tag, ".opcode"}, {26'b0, opcode}, {26'b0, v.op});
  endtask

  // Load a sw-shaped word with rt = r into IR, let B latch RF[r], read it on mem_wdata.
  task automatic read_reg(input logic [4:0] r, output logic [31:0] val);
    logic [31:0] w;
    w = {6'h2B, 5'd0, r, 16'h0000};
    drive(C_IRONLY, w);
    @(posedge clk); #1;
    drive(C_IDLE, 32'h0);
    @(posedge clk); #1;
    val = mem_wdata;
  endtask

  task automatic readback_scoreboard(input string tag);
    logic [4:0]  regs[7];
    logic [31:0] v;
    regs = '{5'd0, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
    foreach (regs[i]) begin
      read_reg(regs[i], v);
      check($sformatf("%s.r%0d", tag, regs[i]), v, exp_q.pop_front());
    end
  endtask

  // ---------------- test ----------------
  initial begin
    ctrl_t c;
    logic [31:0] v;

    // program table: {control, mem_rdata, check mask, pc, opcode, mem_addr, mem_wdata, mem_write, alu_zero}
    // addi $t0,$0,5 @0
    vecs.push_back(mkv(C_FETCH, 32'h2008_0005, M_PC|M_OP|M_ADDR, 32'h4, 6'h08, 32'h0, 0, 0, 0));
    vecs.push_back(mkv(C_DECODE, 0, M_PC, 32'h4, 0, 0, 0, 0, 0));
    vecs.push_back(mk0(C_ADDIEX));
    vecs.push_back(mk0(C_ADDIWB));
    // add $t1,$t0,$t0 @4
    vecs.push_back(mkv(C_FETCH, 32'h0108_4820, M_PC|M_OP|M_ADDR, 32'h8, 6'h00, 32'h4, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mkv(C_EXEC, 0, M_ZERO, 0, 0, 0, 0, 0, 1'b0));
    vecs.push_back(mk0(C_ALUWB));
    // sw $t1,8($0) @8
    vecs.push_back(mkv(C_FETCH, 32'hAC09_0008, M_PC|M_OP|M_ADDR, 32'hC, 6'h2B, 32'h8, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mk0(C_MEMADR));
    vecs.push_back(mkv(C_MEMWR, 0, M_ADDR|M_WR, 0, 0, 32'h8, 32'd10, 1'b1, 0));
    // lw $t2,8($0) @C
    vecs.push_back(mkv(C_FETCH, 32'h8C0A_0008, M_PC|M_OP|M_ADDR|M_WR, 32'h10, 6'h23, 32'hC, 32'd10, 1'b0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mk0(C_MEMADR));
    vecs.push_back(mkv(C_MEMRD, 32'd10, M_ADDR, 0, 0, 32'h8, 0, 0, 0));
    vecs.push_back(mkv(C_MEMWB, 32'hDEAD_BEEF, 5'b0, 0, 0, 0, 0, 0, 0));
    // beq $t0,$t0,+3 @10 -> taken to 0x20
    vecs.push_back(mkv(C_FETCH, 32'h1108_0003, M_PC|M_OP|M_ADDR, 32'h14, 6'h04, 32'h10, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mkv(C_BRANCH, 0, M_PC|M_ZERO, 32'h20, 0, 0, 0, 0, 1'b1));
    // j 0x4 @20 -> back to 0x10
    vecs.push_back(mkv(C_FETCH, 32'h0800_0004, M_PC|M_OP|M_ADDR, 32'h24, 6'h02, 32'h20, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mkv(C_JUMP, 0, M_PC, 32'h10, 0, 0, 0, 0, 0));
    // beq $t0,$t1,+3 @10 -> not taken, stays 0x14
    vecs.push_back(mkv(C_FETCH, 32'h1109_0003, M_PC|M_OP|M_ADDR, 32'h14, 6'h04, 32'h10, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mkv(C_BRANCH, 0, M_PC|M_ZERO, 32'h14, 0, 0, 0, 0, 1'b0));
    // j 0x3FFFFFF @14 -> 0x0FFFFFFC
    vecs.push_back(mkv(C_FETCH, 32'h0BFF_FFFF, M_PC|M_OP|M_ADDR, 32'h18, 6'h02, 32'h14, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mkv(C_JUMP, 0, M_PC, 32'h0FFF_FFFC, 0, 0, 0, 0, 0));
    // add $0,$t0,$t0 @0FFFFFFC (write to R0 must be dropped)
    vecs.push_back(mkv(C_FETCH, 32'h0108_0020, M_PC|M_OP|M_ADDR, 32'h1000_0000, 6'h00, 32'h0FFF_FFFC, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mkv(C_EXEC, 0, M_ZERO, 0, 0, 0, 0, 0, 1'b0));
    vecs.push_back(mk0(C_ALUWB));
    // j 0x40 @10000000 -> 0x10000100
    vecs.push_back(mkv(C_FETCH, 32'h0800_0040, M_PC|M_OP|M_ADDR, 32'h1000_0004, 6'h02, 32'h1000_0000, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mkv(C_JUMP, 0, M_PC, 32'h1000_0100, 0, 0, 0, 0, 0));
    // addi $t3,$0,-1 ; addi $t4,$0,1
    vecs.push_back(mkv(C_FETCH, 32'h200B_FFFF, M_PC|M_ADDR, 32'h1000_0104, 0, 32'h1000_0100, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mk0(C_ADDIEX));
    vecs.push_back(mk0(C_ADDIWB));
    vecs.push_back(mkv(C_FETCH, 32'h200C_0001, M_PC|M_ADDR, 32'h1000_0108, 0, 32'h1000_0104, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mk0(C_ADDIEX));
    vecs.push_back(mk0(C_ADDIWB));
    // slt $t5,$t3,$t4 ; write-back overlaps an IR load, so rd must come from slt
    vecs.push_back(mkv(C_FETCH, 32'h016C_682A, M_PC|M_OP|M_ADDR, 32'h1000_010C, 6'h00, 32'h1000_0108, 0, 0, 0));
    vecs.push_back(mk0(C_DECODE));
    vecs.push_back(mkv(C_EXEC, 0, M_ZERO, 0, 0, 0, 0, 0, 1'b0));
    c = C_ALUWB;
    c.ir_write = 1'b1;
    vecs.push_back(mkv(c, 32'hAC0D_0000, M_OP|M_PC, 32'h1000_010C, 6'h2B, 0, 0, 0, 0));
    vecs.push_back(mk0(C_IDLE));
    vecs.push_back(mkv(C_IDLE, 0, M_WR, 0, 0, 0, 32'd1, 1'b0, 0));

    // reset state
    drive(C_IDLE, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.pc", pc, 32'h0);
    check("reset.opcode", {26'b0, opcode}, 32'h0);
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.mem_wdata", mem_wdata, 32'h0);
    check("reset.mem_write", {31'b0, mem_write}, 32'h0);
    check("reset.alu_zero", {31'b0, alu_zero}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // program table
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // register file contents after the program
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd10);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    readback_scoreboard("prog");

    // lw aborted by reset in its memory-read state
    step(mkv(C_FETCH, 32'h8C0A_0008, M_PC|M_OP, 32'h1000_0110, 6'h23, 0, 0, 0, 0), "abort.if");
    step(mk0(C_DECODE), "abort.id");
    step(mk0(C_MEMADR), "abort.ma");
    drive(C_MEMRD, 32'h1234_5678);
    #2;
    check("abort.mem_addr", mem_addr, 32'h8);
    reset = 1'b1;
    #1;
    check("abort.pc", pc, 32'h0);
    check("abort.opcode", {26'b0, opcode}, 32'h0);
    check("abort.mem_addr_rst", mem_addr, 32'h0);
    check("abort.mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(C_IDLE, 32'h0);
    @(posedge clk); #1;
    check("abort.pc_after", pc, 32'h0);
    repeat (7) exp_q.push_back(32'd0);
    readback_scoreboard("rst");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
